// File: rtl/fft_pkg.sv
// Shared constants, FSM encoding and address bit-reversal
// for the FFT input path.
package fft_pkg;

  localparam int N     = 256;
  localparam int LOG2N = 8;
  localparam int DW    = 32;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_e;

  function automatic logic [LOG2N-1:0] bitrev(
    input logic [LOG2N-1:0] a
  );
    logic [LOG2N-1:0] r;
    r = '0;
    for (int i = 0; i < LOG2N; i++) begin
      r[i] = a[LOG2N-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo_small.sv
// Small register FIFO with occupancy count; head word is
// presented on dout_o without a read cycle.
module sync_fifo_small #(
  parameter int W     = 8,
  parameter int DEPTH = 2,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [W-1:0]  din_i,
  input  logic          pop_i,
  output logic [W-1:0]  dout_o,
  output logic [CW-1:0] count_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign do_pop  = pop_i && (cnt_q != '0);
  assign do_push = push_i &&
                   ((cnt_q != CW'(DEPTH)) || do_pop);

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push) begin
      wr_d = (wr_q == AW'(DEPTH - 1)) ? '0
                                       : wr_q + AW'(1);
    end
    if (do_pop) begin
      rd_d = (rd_q == AW'(DEPTH - 1)) ? '0
                                       : rd_q + AW'(1);
    end
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      if (do_push) begin
        mem_q[wr_q] <= din_i;
      end
    end
  end

  assign dout_o  = mem_q[rd_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/bitrev_frame_reader.sv
// Streams one frame from the sample RAM to the FFT core in
// bit-reversed (or natural) order over valid/ready.
module bitrev_frame_reader
  import fft_pkg::*;
#(
  parameter int RAM_LAT = 1,
  parameter int BITREV  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [LOG2N-1:0] ram_addr,
  output logic             ram_rd,
  input  logic [DW-1:0]    ram_dout,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [DW-1:0]    m_data,
  output logic [LOG2N-1:0] m_index,
  output logic             m_last
);

  localparam int DEPTH = RAM_LAT + 1;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int FW    = DW + LOG2N + 1;
  localparam logic [LOG2N:0] KLAST = (LOG2N+1)'(N - 1);

  state_e             state_q, state_d;
  logic [LOG2N:0]     k_q, k_d;
  logic [LOG2N-1:0]   kk;
  logic [RAM_LAT-1:0] pv_q;
  logic [LOG2N-1:0]   pk_q [RAM_LAT];
  logic [LOG2N-1:0]   pk_out;
  logic [CW-1:0]      cnt;
  logic [FW-1:0]      f_din, f_dout;
  logic               issue, pop, credit;

  assign kk  = k_q[LOG2N-1:0];
  assign pop = m_valid && m_ready;

  // A slot freed by this cycle's pop can be reused at once,
  // which keeps the stream bubble-free under m_ready=1.
  always_comb begin
    credit = (int'(cnt) + $countones(pv_q) - int'(pop))
             < DEPTH;
  end

  assign issue = (state_q == RUN) && !k_q[LOG2N] && credit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (issue && k_q == KLAST) state_d = DRAIN;
      DRAIN:   if (pop && m_last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state_q == RUN) || (state_q == DRAIN);
    done     = (state_q == DONE);
    ram_rd   = issue;
    ram_addr = (BITREV != 0) ? bitrev(kk) : kk;
  end

  always_comb begin
    k_d = k_q;
    if (state_q == IDLE && start) begin
      k_d = '0;
    end else if (issue) begin
      k_d = k_q + (LOG2N+1)'(1);
    end else if (state_q == DONE) begin
      k_d = '0;
    end
  end

  // Issue index travels alongside the read so returning
  // data is tagged with its natural-order position.
  always_ff @(posedge clk) begin
    if (rst) begin
      k_q  <= '0;
      pv_q <= '0;
      for (int i = 0; i < RAM_LAT; i++) begin
        pk_q[i] <= '0;
      end
    end else begin
      k_q     <= k_d;
      pv_q[0] <= issue;
      pk_q[0] <= kk;
      for (int i = 1; i < RAM_LAT; i++) begin
        pv_q[i] <= pv_q[i-1];
        pk_q[i] <= pk_q[i-1];
      end
    end
  end

  assign pk_out = pk_q[RAM_LAT-1];
  assign f_din  = {pk_out == KLAST[LOG2N-1:0],
                   pk_out, ram_dout};

  sync_fifo_small #(
    .W     (FW),
    .DEPTH (DEPTH)
  ) u_ret (
    .clk     (clk),
    .rst     (rst),
    .push_i  (pv_q[RAM_LAT-1]),
    .din_i   (f_din),
    .pop_i   (pop),
    .dout_o  (f_dout),
    .count_o (cnt)
  );

  assign m_valid = (cnt != '0);
  assign {m_last, m_index, m_data} = f_dout;

endmodule

// File: tb/tb_bitrev_frame_reader.sv
// Bench: bit-reversed and natural-order readers side by side
// against a frame-level reference model.
module tb_bitrev_frame_reader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic m_ready = 1'b0;

  logic b_busy, b_done, b_rd, b_valid, b_last;
  logic [7:0] b_addr, b_index;
  logic [31:0] b_dout, b_data;
  logic n_busy, n_done, n_rd, n_valid, n_last;
  logic [7:0] n_addr, n_index;
  logic [31:0] n_dout, n_data;

  logic [31:0] mem [256];

  int nvec = 0;
  int nerr = 0;
  int cyc = 0;

  int exp_k [2];
  int frames [2];
  int dones [2];
  int issued [2];
  int xfers [2];
  int max_ahead [2];
  logic stall_prev [2];
  logic [7:0] pi [2];
  logic [31:0] pd [2];
  logic pl [2];

  logic [31:0] cap_data [256];
  logic cap_last [256];
  int first_x, last_x, done_cyc;

  typedef struct {
    int k;
    logic [31:0] data;
    logic last;
  } vec_t;
  vec_t tbl [5];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) if (b_rd) b_dout <= mem[b_addr];
  always @(posedge clk) if (n_rd) n_dout <= mem[n_addr];

  bitrev_frame_reader #(.RAM_LAT(1), .BITREV(1)) dut_b (
    .clk(clk), .rst(rst), .start(start),
    .busy(b_busy), .done(b_done),
    .ram_addr(b_addr), .ram_rd(b_rd), .ram_dout(b_dout),
    .m_valid(b_valid), .m_ready(m_ready),
    .m_data(b_data), .m_index(b_index), .m_last(b_last)
  );

  bitrev_frame_reader #(.RAM_LAT(1), .BITREV(0)) dut_n (
    .clk(clk), .rst(rst), .start(start),
    .busy(n_busy), .done(n_done),
    .ram_addr(n_addr), .ram_rd(n_rd), .ram_dout(n_dout),
    .m_valid(n_valid), .m_ready(m_ready),
    .m_data(n_data), .m_index(n_index), .m_last(n_last)
  );

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  function automatic int rev8(input int a);
    int r = 0;
    int v = a;
    for (int i = 0; i < 8; i++) begin
      r = r * 2 + (v % 2);
      v = v / 2;
    end
    return r;
  endfunction

  task automatic mon(input int d, input logic v,
                     input logic rd, input logic dn,
                     input logic lst, input logic [7:0] idx,
                     input logic [31:0] dat);
    int a;
    logic [31:0] ed;
    if (rst) begin
      exp_k[d] = 0;
      issued[d] = 0;
      xfers[d] = 0;
      stall_prev[d] = 1'b0;
      return;
    end
    if (stall_prev[d]) begin
      chk("hold", {v, idx, dat, lst},
          {1'b1, pi[d], pd[d], pl[d]});
    end
    if (rd) issued[d]++;
    if (dn) begin
      dones[d]++;
      if (d == 0) done_cyc = cyc;
    end
    if (v && m_ready) begin
      a = (d == 0) ? rev8(exp_k[d]) : exp_k[d];
      ed = mem[a];
      chk("index", idx, exp_k[d]);
      chk("data", dat, ed);
      chk("last", lst, exp_k[d] == 255);
      xfers[d]++;
      if (d == 0) begin
        cap_data[exp_k[d]] = dat;
        cap_last[exp_k[d]] = lst;
        if (exp_k[d] == 0) first_x = cyc;
        if (exp_k[d] == 255) last_x = cyc;
      end
      if (exp_k[d] == 255) begin
        frames[d]++;
        exp_k[d] = 0;
      end else begin
        exp_k[d]++;
      end
    end
    a = issued[d] - xfers[d];
    if (a > max_ahead[d]) max_ahead[d] = a;
    stall_prev[d] = v && !m_ready;
    pi[d] = idx;
    pd[d] = dat;
    pl[d] = lst;
  endtask

  always @(negedge clk) begin
    mon(0, b_valid, b_rd, b_done, b_last, b_index, b_data);
    mon(1, n_valid, n_rd, n_done, n_last, n_index, n_data);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int lim);
    int n = 0;
    while (b_done !== 1'b1 && n < lim) begin
      tick();
      n++;
    end
    chk("done_seen", b_done, 1'b1);
  endtask

  initial begin
    int n, dn0, fr0, busy_bad;
    bit held, s2;

    tbl[0] = '{0,   32'h00, 1'b0};
    tbl[1] = '{1,   32'h80, 1'b0};
    tbl[2] = '{2,   32'h40, 1'b0};
    tbl[3] = '{100, 32'h26, 1'b0};
    tbl[4] = '{255, 32'hFF, 1'b1};
    for (int i = 0; i < 256; i++) mem[i] = i;
    for (int d = 0; d < 2; d++) begin
      frames[d] = 0;
      dones[d] = 0;
      max_ahead[d] = 0;
    end

    repeat (3) tick();
    chk("rst_busy", b_busy, 0);
    chk("rst_done", b_done, 0);
    chk("rst_rd", b_rd, 0);
    chk("rst_addr", b_addr, 0);
    chk("rst_valid", b_valid, 0);
    chk("rst_data", b_data, 0);
    chk("rst_index", b_index, 0);
    chk("rst_last", b_last, 0);
    rst = 1'b0;
    tick();

    // free-run, both orders in parallel
    m_ready = 1'b1;
    pulse_start();
    chk("t0_busy", b_busy, 1);
    chk("t0_rd", b_rd, 1);
    chk("t0_valid", b_valid, 0);
    tick();
    chk("t1_valid", b_valid, 0);
    tick();
    chk("t2_valid", b_valid, 1);
    chk("t2_index", b_index, 0);
    wait_done(400);
    chk("done_busy", b_busy, 0);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("tbl_data", cap_data[tbl[i].k], tbl[i].data);
      chk("tbl_last", cap_last[tbl[i].k], tbl[i].last);
    end
    chk("no_bubble", last_x - first_x, 255);
    chk("done_lat", done_cyc, last_x + 1);
    chk("nat_frame", frames[1], 1);

    // backpressure plus a start while busy
    dn0 = dones[0];
    held = 0;
    s2 = 0;
    busy_bad = 0;
    n = 0;
    pulse_start();
    while (b_done !== 1'b1 && n < 5000) begin
      if (!held && b_valid && b_index == 8'd100) begin
        m_ready = 1'b0;
        repeat (20) begin
          tick();
          chk("stall_data", b_data, 32'h26);
        end
        held = 1;
      end
      m_ready = ($urandom_range(0, 9) < 3);
      if (!s2 && b_valid && b_index == 8'd50) begin
        start = 1'b1;
        s2 = 1;
      end
      tick();
      start = 1'b0;
      n++;
      if (b_done !== 1'b1 && b_busy !== 1'b1) busy_bad++;
    end
    chk("bp_done", b_done, 1);
    chk("bp_held", held, 1);
    chk("bp_busy", busy_bad, 0);
    m_ready = 1'b1;
    repeat (4) tick();
    chk("bp_one_done", dones[0] - dn0, 1);
    chk("bp_idle", b_busy, 0);
    chk("bp_ahead", max_ahead[0] <= 2, 1);

    // reset mid-frame, then a clean frame
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    pulse_start();
    n = 0;
    while (!(b_valid && b_index == 8'd128) && n < 400) begin
      tick();
      n++;
    end
    chk("reach128", b_valid && b_index == 8'd128, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mr_valid", b_valid, 0);
    chk("mr_busy", b_busy, 0);
    chk("mr_done", b_done, 0);
    chk("mr_rd", b_rd, 0);
    dn0 = dones[0];
    repeat (5) tick();
    chk("mr_no_done", dones[0] - dn0, 0);
    fr0 = frames[0];
    pulse_start();
    wait_done(400);
    tick();
    chk("mr_frame", frames[0] - fr0, 1);

    // back-to-back frames
    fr0 = frames[0];
    pulse_start();
    wait_done(400);
    tick();
    pulse_start();
    chk("b2b_busy", b_busy, 1);
    wait_done(400);
    // start coinciding with done must be dropped
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("sd_busy0", b_busy, 0);
    tick();
    chk("sd_busy1", b_busy, 0);
    chk("sd_rd", b_rd, 0);
    chk("b2b_frames", frames[0] - fr0, 2);

    chk("tot_frames_b", frames[0], 5);
    chk("tot_frames_n", frames[1], 5);
    chk("tot_dones", dones[0], 5);
    chk("ahead_b", max_ahead[0] <= 2, 1);
    chk("ahead_n", max_ahead[1] <= 2, 1);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

endmodule

// File: doc/bitrev_frame_reader.md
Name: bitrev_frame_reader

Overview:
Downstream stage of the filter. Once a frame is complete, this block reads the 256-entry filtered-sample RAM (32-bit single-precision words, synchronous read) in bit-reversed address order. It streams the samples to the radix-2 FFT core over a valid/ready handshake. It absorbs the RAM read latency and FFT backpressure with no lost or duplicated samples, then reports frame completion to the top-level sequencer.

Parameters:
N, 256, frame length in samples; must be a power of 2.
LOG2N, 8, address width; equals log2(N).
DW, 32, sample width (IEEE-754 single, passed through untouched).
RAM_LAT, 1, RAM read latency in cycles from address to data.
BITREV, 1, 1 = bit-reversed read order, 0 = natural order.

Ports:
clk  input  1  clock; all logic on rising edge.
rst  input  1  synchronous reset, active-high.
start  input  1  one-cycle request to stream one frame.
busy  output  1  high from the cycle after an accepted start until done.
done  output  1  one-cycle pulse after the final sample handshake.
ram_addr  output  LOG2N  read address to the filtered-sample RAM.
ram_rd  output  1  high on cycles that issue a read.
ram_dout  input  DW  RAM read data, valid RAM_LAT cycles after ram_rd.
m_valid  output  1  output sample valid.
m_ready  input  1  FFT core can accept a sample.
m_data  output  DW  sample value.
m_index  output  LOG2N  natural-order issue index k; the sample is RAM[bitrev(k)].
m_last  output  1  high with the sample where k = N-1.

Behaviour:
- Clock and reset: clock clk. Reset rst is synchronous and active-high.
- Reset values: busy=0, done=0, ram_rd=0, ram_addr=0, m_valid=0, m_data=0, m_index=0, m_last=0. All counters and the FIFO are cleared and state = IDLE.
- State machine:
  - IDLE --start--> RUN. Issue counter k and credit count are cleared.
  - RUN: issue reads while k < N. On the read with k = N-1, go to DRAIN.
  - DRAIN: wait for the m_last handshake, then go to DONE.
  - DONE: done=1 for one cycle, busy drops, return to IDLE.
- Start rules: start is accepted only in IDLE and is ignored while busy. start asserted in the same cycle as done is also ignored.
- Read issue:
  - ram_rd=1 with ram_addr = BITREV ? bit-reverse of k : k, then k increments.
  - A read issues only when (FIFO occupancy + reads in flight) < FIFO depth. FIFO depth = RAM_LAT+1 (2 by default). This credit rule guarantees returning data always has a slot.
- Return path: ram_dout is captured RAM_LAT cycles after ram_rd, together with its k (delayed through a matching shift register), into a small FIFO. The FIFO head drives m_data, m_index and m_last.
- Handshake:
  - A transfer occurs when m_valid && m_ready.
  - While m_valid=1 and m_ready=0, m_data, m_index and m_last hold stable and m_valid stays high.
  - m_valid never depends combinationally on m_ready.
- Latency and throughput:
  - start sampled at edge T0; first ram_rd at T1; first m_valid at T1+RAM_LAT+1.
  - With m_ready held high: one sample per cycle, no bubbles after the first.
  - done fires on the cycle after the m_last transfer.
- Backpressure: m_ready low for any duration stalls issue once credits are exhausted. No data is dropped and order is preserved.
- Boundary conditions:
  - k wraps to 0 only when a frame ends.
  - m_index runs 0..N-1 exactly once per frame.
- Reset mid-frame: outputs return to reset values at the next edge. No done pulse is produced and any in-flight RAM data is discarded.
- Arithmetic: data is pass-through with no arithmetic on DW bits. Counters are LOG2N+1 bits wide so that k = N is detectable.

Decomposition:
- Shared package fft_pkg: N, LOG2N, DW, a bitrev function (LOG2N-bit), and state encodings IDLE/RUN/DRAIN/DONE.
- One natural sub-module: sync_fifo_small. It is a parameterised-depth register FIFO (depth RAM_LAT+1) with count output, used for the return buffer.

Test Plan:
- Free-run, BITREV=1: RAM preloaded with RAM[a]=a. Pulse start with m_ready=1 -> 256 contiguous transfers. (index 0, data 0x00), (index 1, data 0x80), (index 2, data 0x40), (index 255, data 0xFF, m_last=1). done pulses one cycle later; first m_valid appears 3 cycles after the start edge.
- Natural order, BITREV=0: same preload -> data equals index for all 256 samples.
- Backpressure: m_ready toggles with a random 30% duty and is held low for 20 cycles at index 100 -> m_data stays 0x26 (bitrev of 100) throughout the stall. Sequence is complete, in order and free of duplicates; ram_rd never runs more than 2 reads ahead of consumption.
- Start while busy: second start at index 50 -> ignored. Exactly one done; busy stays continuously high until done.
- Reset mid-frame: rst asserted at index 128 for one cycle -> m_valid=0 and busy=0 at the next edge with no done. A new start then streams a full frame from index 0.
- Back-to-back frames: start is asserted the cycle after done -> a second full 256-sample frame is delivered with correct m_last and a second done.
